// File: rtl/pattern_pkg.sv
// pattern_pkg: mode encodings, FSM states, line lengths and config struct for the pattern timing path
package pattern_pkg;
  typedef enum logic [2:0] {
    MODE_OFF   = 3'b000,
    REGULAR    = 3'b001,
    CONST_MODE = 3'b010,
    HRAMP_MODE = 3'b011,
    VRAMP_MODE = 3'b100,
    CHECK_MODE = 3'b101,
    BAR_MODE   = 3'b110,
    RAMP_MODE  = 3'b111
  } mode_e;
  typedef enum logic [1:0] {IDLE, LINE, VBLANK} state_e;
  localparam int LINE_LEN = 1290;
  localparam int REG_LINE_LEN = 4096;
  typedef struct packed {
    logic [2:0]  mode;
    logic [11:0] const_val;
    logic [1:0]  x;
    logic [1:0]  y;
  } pattern_cfg_t;
  function automatic logic [15:0] line_period(input logic [2:0] mode, input int lp, input int rp);
    return (mode == REGULAR) ? 16'(rp) : 16'(lp);
  endfunction
endpackage

// File: rtl/pattern_cfg_shadow.sv
// pattern_cfg_shadow: pending (host-written) and active (frame-latched) pattern configuration
module pattern_cfg_shadow
  import pattern_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic         apply,
  input  pattern_cfg_t cfg_in,
  output logic [2:0]   pend_mode,
  output pattern_cfg_t active
);
  pattern_cfg_t pend_q, pend_d, act_q, act_d;
  // Host writes land in pending; apply copies the pre-edge pending value to active.
  always_comb begin
    pend_d = cfg_valid ? cfg_in : pend_q;
    act_d = apply ? pend_q : act_q;
  end
  // Shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      act_q <= '0;
    end else begin
      pend_q <= pend_d;
      act_q <= act_d;
    end
  end
  assign pend_mode = pend_q.mode;
  assign active = act_q;
endmodule

// File: rtl/pattern_timing_gen.sv
// pattern_timing_gen: frame/line sync timing with frame-latched pattern configuration.
// Define PATTERN_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module pattern_timing_gen
  import pattern_pkg::*;
#(
  parameter int LINES_PER_FRAME = 24,
  parameter int LINE_PERIOD = 1300,
  parameter int REG_LINE_PERIOD = 4100,
  parameter int VBLANK_LINES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_mode,
  input  logic [11:0] cfg_const,
  input  logic [1:0]  cfg_x,
  input  logic [1:0]  cfg_y,
  output logic        f_sync,
  output logic        sync,
  output logic [2:0]  Mode,
  output logic [11:0] constVal,
  output logic [1:0]  X,
  output logic [1:0]  Y,
  output logic [4:0]  line_idx,
`ifdef PATTERN_TIMING_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_active
);
  // per must hold VBLANK_LINES*P-1; 13 bits suffice only while that stays below 8192.
  localparam int PER_W = (VBLANK_LINES * REG_LINE_PERIOD > 8192 || VBLANK_LINES * LINE_PERIOD > 8192) ? 16 : 13;
  state_e state_q, state_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [15:0] p_q, p_d, p_new;
  logic [4:0] line_q, line_d;
  logic sync_q, sync_d, fsync_q, fsync_d, fa_q, fa_d, start, last;
  logic [2:0] pend_mode;
  pattern_cfg_t act;
  pattern_cfg_shadow u_shadow (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .apply(start),
    .cfg_in({cfg_mode, cfg_const, cfg_x, cfg_y}),
    .pend_mode(pend_mode),
    .active(act)
  );
  // Next-state: start a frame from IDLE, step lines every P cycles, then hold off for the vblank.
  always_comb begin
    start = state_q == IDLE && enable && pend_mode != MODE_OFF;
    last = line_q == 5'(LINES_PER_FRAME - 1);
    p_new = line_period(pend_mode, LINE_PERIOD, REG_LINE_PERIOD);
    state_d = state_q;
    per_d = per_q;
    p_d = p_q;
    line_d = line_q;
    fa_d = fa_q;
    sync_d = 1'b0;
    fsync_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        p_d = p_new;
        per_d = PER_W'(p_new - 16'd1);
        line_d = 5'd0;
        fa_d = 1'b1;
        sync_d = 1'b1;
        fsync_d = 1'b1;
        state_d = LINE;
      end
      LINE: if (per_q != '0) per_d = per_q - PER_W'(1);
      else if (!last) begin
        sync_d = 1'b1;
        line_d = line_q + 5'd1;
        per_d = PER_W'(p_q - 16'd1);
      end else begin
        fa_d = 1'b0;
        per_d = PER_W'(16'(VBLANK_LINES) * p_q - 16'd1);
        state_d = VBLANK;
      end
      VBLANK: if (per_q != '0) per_d = per_q - PER_W'(1);
      else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      per_q <= '0;
      p_q <= '0;
      line_q <= '0;
      fa_q <= 1'b0;
      sync_q <= 1'b0;
      fsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q <= per_d;
      p_q <= p_d;
      line_q <= line_d;
      fa_q <= fa_d;
      sync_q <= sync_d;
      fsync_q <= fsync_d;
    end
  end
`ifdef PATTERN_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  // Count frame starts; wraps naturally at 16 bits.
  always_comb fcnt_d = fsync_d ? fcnt_q + 16'd1 : fcnt_q;
  // Frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt_q <= '0;
    else fcnt_q <= fcnt_d;
  end
  assign frame_cnt = fcnt_q;
`endif
  assign f_sync = fsync_q;
  assign sync = sync_q;
  assign line_idx = line_q;
  assign frame_active = fa_q;
  assign Mode = act.mode;
  assign constVal = act.const_val;
  assign X = act.x;
  assign Y = act.y;
endmodule

// File: tb/tb_pattern_timing_gen.sv
// tb_pattern_timing_gen: randomized-config bench against a timestamp-based reference model
module tb_pattern_timing_gen;
  localparam int L = 6;
  localparam int LP = 1300;
  localparam int RP = 4100;
  localparam int VB = 2;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
  logic [2:0] cfg_mode = '0;
  logic [11:0] cfg_const = '0;
  logic [1:0] cfg_x = '0, cfg_y = '0;
  logic f_sync, sync, frame_active;
  logic [2:0] Mode;
  logic [11:0] constVal;
  logic [1:0] X, Y;
  logic [4:0] line_idx;
`ifdef PATTERN_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;

  pattern_timing_gen #(.LINES_PER_FRAME(L), .LINE_PERIOD(LP), .REG_LINE_PERIOD(RP), .VBLANK_LINES(VB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_const(cfg_const), .cfg_x(cfg_x), .cfg_y(cfg_y), .f_sync(f_sync), .sync(sync),
    .Mode(Mode), .constVal(constVal), .X(X), .Y(Y), .line_idx(line_idx),
`ifdef PATTERN_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_active(frame_active)
  );

  // Reference model: a frame started at edge t0 has line k starting at t0+k*P; next start
  // is allowed no earlier than t0+(L+VB)*P+1.
  longint m_cyc, m_t0, m_idle_at, d;
  logic m_have, m_start;
  int m_p, m_np, m_frames;
  logic [18:0] m_pend, m_act;
  logic e_fs, e_sync, e_fa;
  logic [4:0] e_line;
  logic [42:0] dv, ev;
  assign m_np = (m_pend[18:16] == 3'b001) ? RP : LP;
  assign m_start = m_cyc >= m_idle_at && enable && m_pend[18:16] != 3'b000;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_t0 <= 0; m_idle_at <= 0; m_have <= 1'b0; m_p <= LP;
      m_pend <= '0; m_act <= '0; m_frames <= 0;
    end else begin
      if (m_start) begin
        m_t0 <= m_cyc; m_have <= 1'b1; m_act <= m_pend; m_p <= m_np;
        m_idle_at <= m_cyc + longint'((L + VB) * m_np) + 1;
        m_frames <= m_frames + 1;
      end
      if (cfg_valid) m_pend <= {cfg_mode, cfg_const, cfg_x, cfg_y};
      m_cyc <= m_cyc + 1;
    end
  end
  always_comb begin
    d = m_cyc - 1 - m_t0;
    e_fa = m_have && d < longint'(L * m_p);
    e_sync = e_fa && (d % m_p) == 0;
    e_fs = m_have && d == 0;
    e_line = m_have ? 5'((d / m_p >= L) ? longint'(L - 1) : d / m_p) : 5'd0;
  end
`ifdef PATTERN_TIMING_FRAME_CNT_EN
  assign dv = {frame_cnt, f_sync, sync, frame_active, line_idx, Mode, constVal, X, Y};
  assign ev = {16'(m_frames), e_fs, e_sync, e_fa, e_line, m_act};
`else
  assign dv = {16'd0, f_sync, sync, frame_active, line_idx, Mode, constVal, X, Y};
  assign ev = {16'd0, e_fs, e_sync, e_fa, e_line, m_act};
`endif

  task automatic test_reset;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vecs++;
      if (dv !== 43'd0) begin errs++; $display("FAIL reset got=%h exp=0", dv); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int off, last, nsync, fa_fall;
    logic [4:0] prev_line;
    cfg_valid = 1'b1; cfg_mode = 3'b010; cfg_const = 12'h5A5; cfg_x = 2'($urandom); cfg_y = 2'($urandom);
    @(negedge clk);
    cfg_valid = 1'b0; enable = 1'b1; off = 0;
    do begin
      @(negedge clk); off++; vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL basic_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
    end while (!f_sync && off < 20);
    vecs++;
    if ({f_sync, sync, constVal, Mode} !== {2'b11, 12'h5A5, 3'b010})
      begin errs++; $display("FAIL basic_first got=%b%b %h %b exp=11 5a5 010", f_sync, sync, constVal, Mode); end
    off = 0; last = 0; nsync = 1; fa_fall = -1; prev_line = line_idx;
    do begin
      prev_line = line_idx;
      @(negedge clk); off++; vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL basic_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
      if (sync && !f_sync) begin
        nsync++; vecs++;
        if (off - last != LP) begin errs++; $display("FAIL basic_spacing got=%0d exp=%0d", off - last, LP); end
        last = off;
      end
      if (!frame_active && fa_fall < 0) fa_fall = off;
      cfg_valid = (off == 2000);
      if (off == 2000) begin cfg_mode = 3'b011; cfg_const = 12'($urandom); cfg_x = 2'($urandom); cfg_y = 2'($urandom); end
    end while (!f_sync && off < 12000);
    vecs++; if (nsync != L) begin errs++; $display("FAIL basic_nsync got=%0d exp=%0d", nsync, L); end
    vecs++; if (off != (L + VB) * LP + 1) begin errs++; $display("FAIL basic_frame_gap got=%0d exp=%0d", off, (L + VB) * LP + 1); end
    vecs++; if (fa_fall != L * LP) begin errs++; $display("FAIL basic_fa_fall got=%0d exp=%0d", fa_fall, L * LP); end
    vecs++; if ({prev_line, line_idx} !== {5'(L - 1), 5'd0}) begin errs++; $display("FAIL basic_line_wrap got=%0d->%0d exp=%0d->0", prev_line, line_idx, L - 1); end
    vecs++; if (Mode !== 3'b011) begin errs++; $display("FAIL basic_next_mode got=%b exp=011", Mode); end
  endtask

  task automatic test_cfg_update;
    int f;
    f = (L + VB) * LP + 1;
    for (int off = 1; off <= f; off++) begin
      @(negedge clk); vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL cfg_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
      if (off < f) begin
        vecs++;
        if (Mode !== 3'b011) begin errs++; if (errs <= 20) $display("FAIL cfg_hold got=%b exp=011", Mode); end
      end
      cfg_valid = (off == 3000 || off == f - 1);
      if (off == 3000) begin cfg_mode = 3'b111; cfg_x = 2'b10; cfg_y = 2'b01; cfg_const = 12'($urandom); end
      if (off == f - 1) begin cfg_mode = 3'b001; cfg_x = 2'($urandom); cfg_y = 2'($urandom); cfg_const = 12'($urandom); end
    end
    vecs++;
    if ({f_sync, Mode, X, Y} !== {1'b1, 3'b111, 2'b10, 2'b01})
      begin errs++; $display("FAIL cfg_apply got=%b %b %b %b exp=1 111 10 01", f_sync, Mode, X, Y); end
`ifdef PATTERN_TIMING_FRAME_CNT_EN
    vecs++; if (frame_cnt !== 16'd3) begin errs++; $display("FAIL frame_cnt got=%0d exp=3", frame_cnt); end
`endif
  endtask

  task automatic test_regular_enable_drop;
    int off, last, nsync, nfs, maxl;
    off = 0;
    do begin
      @(negedge clk); off++; vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL reg_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
    end while (!f_sync && off < (L + VB) * LP + 10);
    vecs++; if ({f_sync, Mode} !== {1'b1, 3'b001}) begin errs++; $display("FAIL reg_start got=%b %b exp=1 001", f_sync, Mode); end
    last = 0; nsync = 1; nfs = 0; maxl = 0;
    for (off = 1; off <= (L + VB) * RP + 3000; off++) begin
      @(negedge clk); vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL reg_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
      if (f_sync) nfs++;
      if (sync) begin
        nsync++; vecs++;
        if (off - last != RP) begin errs++; $display("FAIL reg_spacing got=%0d exp=%0d", off - last, RP); end
        last = off;
      end
      if (int'(line_idx) > maxl) maxl = int'(line_idx);
      if (off == 2 * RP + 100) enable = 1'b0;
    end
    vecs++; if (nsync != L) begin errs++; $display("FAIL reg_nsync got=%0d exp=%0d", nsync, L); end
    vecs++; if (maxl != L - 1) begin errs++; $display("FAIL reg_max_line got=%0d exp=%0d", maxl, L - 1); end
    vecs++; if (nfs != 0) begin errs++; $display("FAIL drop_no_fsync got=%0d exp=0", nfs); end
    vecs++; if (frame_active !== 1'b0) begin errs++; $display("FAIL drop_idle got=%b exp=0", frame_active); end
  endtask

  task automatic test_reset_mid;
    int off;
    cfg_valid = 1'b1; cfg_mode = 3'b010; cfg_const = 12'($urandom);
    @(negedge clk);
    cfg_valid = 1'b0; enable = 1'b1; off = 0;
    do begin
      @(negedge clk); off++; vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL rst_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
    end while (!f_sync && off < 20);
    for (int i = 0; i < 3 * LP + 650; i++) begin
      @(negedge clk); vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL rst_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
    end
    vecs++; if (line_idx !== 5'd3) begin errs++; $display("FAIL rst_pre_line got=%0d exp=3", line_idx); end
    #3 rst = 1'b1;
    #1 vecs++;
    if (dv !== 43'd0) begin errs++; $display("FAIL rst_immediate got=%h exp=0", dv); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); vecs++;
      if (dv !== 43'd0) begin errs++; $display("FAIL rst_hold got=%h exp=0", dv); end
    end
    rst = 1'b0;
  endtask

  task automatic test_mode_zero;
    int ns;
    enable = 1'b1; ns = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); vecs++;
      if (dv !== ev) begin errs++; if (errs <= 20) $display("FAIL zero_cycle t=%0t got=%h exp=%h", $time, dv, ev); end
      if (sync || f_sync) ns++;
    end
    vecs++; if (ns != 0) begin errs++; $display("FAIL zero_no_sync got=%0d exp=0", ns); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_cfg_update;
    test_regular_enable_drop;
    test_reset_mid;
    test_mode_zero;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
